// File: rtl/lsu_pkg.sv
// rtl/lsu_pkg.sv - shared types, mem_op codes and bus field offsets for the lsu
package lsu_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2,
        ST_DONE = 2'd3
    } lsu_state_e;

    // mem_op uses the load/store funct3 coding
    localparam logic [2:0] OP_B  = 3'b000;
    localparam logic [2:0] OP_H  = 3'b001;
    localparam logic [2:0] OP_W  = 3'b010;
    localparam logic [2:0] OP_BU = 3'b100;
    localparam logic [2:0] OP_HU = 3'b101;

    localparam int EXU_LSU_W = 156;
    localparam int LSU_WBU_W = 119;

    // LSU->WBU bus, LSB first:
    // {skip, pc, csr_we, final_result, gr_we, rd, csr_addr, csr_wdata, break, excp_flush, xret_flush}
    localparam int WB_XRET     = 0;
    localparam int WB_EXCP     = 1;
    localparam int WB_BRK      = 2;
    localparam int WB_CSRWD_LO = 3;
    localparam int WB_CSRA_LO  = 35;
    localparam int WB_RD_LO    = 47;
    localparam int WB_GRWE     = 52;
    localparam int WB_FR_LO    = 53;
    localparam int WB_FR_HI    = 84;
    localparam int WB_CSRWE    = 85;
    localparam int WB_PC_LO    = 86;
    localparam int WB_SKIP     = 118;

    // EXU->LSU bus adds {mem_en, mem_we, mem_op, mem_wdata} above the LSU->WBU field set
    localparam int EX_WDATA_LO = 119;
    localparam int EX_WDATA_HI = 150;
    localparam int EX_OP_LO    = 151;
    localparam int EX_OP_HI    = 153;
    localparam int EX_WE       = 154;
    localparam int EX_EN       = 155;

    // Device-window membership test used for difftest skipping
    function automatic logic in_window(input logic [31:0] addr,
                                       input logic [31:0] base,
                                       input logic [31:0] mask);
        return (addr & mask) == base;
    endfunction

endpackage

// File: rtl/lsu_align.sv
// rtl/lsu_align.sv - load extract/extend, store strobes/replication, misalign detect (LSU_MISALIGN_EXCP_EN)
import lsu_pkg::*;

module lsu_align (
    input  logic [31:0] req_addr_i,
    input  logic [2:0]  req_op_i,
    input  logic [31:0] req_wdata_i,
    output logic [31:0] req_addr_o,
    output logic [3:0]  req_wstrb_o,
    output logic [31:0] req_wdata_o,
    output logic        misalign_o,
    input  logic [1:0]  ld_addr_i,
    input  logic [2:0]  ld_op_i,
    input  logic [31:0] ld_rdata_i,
    output logic [31:0] ld_data_o
);

    logic       is_b;
    logic       is_h;
    logic       is_w;
    logic [1:0] a;
    logic [1:0] a_eff;

    // Request side: width class, effective lane offset, strobes and replicated data
    always_comb begin
        a    = req_addr_i[1:0];
        is_b = (req_op_i == OP_B) || (req_op_i == OP_BU);
        is_h = (req_op_i == OP_H) || (req_op_i == OP_HU);
        is_w = !is_b && !is_h;
`ifdef LSU_MISALIGN_EXCP_EN
        a_eff      = a;
        misalign_o = (is_h && a[0]) || (is_w && (a != 2'b00));
`else
        // Misaligned accesses are silently aligned down to their natural boundary
        if (is_w) begin
            a_eff = 2'b00;
        end else if (is_h) begin
            a_eff = {a[1], 1'b0};
        end else begin
            a_eff = a;
        end
        misalign_o = 1'b0;
`endif
        req_addr_o = {req_addr_i[31:2], a_eff};
        if (is_b) begin
            req_wstrb_o = 4'b0001 << a_eff;
            req_wdata_o = {4{req_wdata_i[7:0]}};
        end else if (is_h) begin
            req_wstrb_o = 4'b0011 << {a_eff[1], 1'b0};
            req_wdata_o = {2{req_wdata_i[15:0]}};
        end else begin
            req_wstrb_o = 4'b1111;
            req_wdata_o = req_wdata_i;
        end
    end

    logic [7:0]  ld_byte;
    logic [15:0] ld_half;

    // Response side: pick the addressed lane and sign/zero extend
    always_comb begin
        case (ld_addr_i)
            2'd0:    ld_byte = ld_rdata_i[7:0];
            2'd1:    ld_byte = ld_rdata_i[15:8];
            2'd2:    ld_byte = ld_rdata_i[23:16];
            default: ld_byte = ld_rdata_i[31:24];
        endcase
        ld_half = ld_addr_i[1] ? ld_rdata_i[31:16] : ld_rdata_i[15:0];
        case (ld_op_i)
            OP_B:    ld_data_o = {{24{ld_byte[7]}}, ld_byte};
            OP_BU:   ld_data_o = {24'h0, ld_byte};
            OP_H:    ld_data_o = {{16{ld_half[15]}}, ld_half};
            OP_HU:   ld_data_o = {16'h0, ld_half};
            default: ld_data_o = ld_rdata_i;
        endcase
    end

endmodule

// File: rtl/lsu.sv
// rtl/lsu.sv - load/store stage between execute and writeback (optional LSU_MISALIGN_EXCP_EN)
import lsu_pkg::*;

module lsu #(
    parameter logic [31:0] DEV_BASE = 32'ha000_0000,
    parameter logic [31:0] DEV_MASK = 32'hf000_0000
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         exu_valid_i,
    input  logic [155:0] exu_lsu_bus_i,
    output logic         lsu_ready_o,
    output logic         lsu_valid_o,
    output logic [118:0] lsu_wbu_bus_o,
    input  logic         wbu_ready_i,
    output logic         mem_req_valid_o,
    input  logic         mem_req_ready_i,
    output logic [31:0]  mem_addr_o,
    output logic         mem_we_o,
    output logic [31:0]  mem_wdata_o,
    output logic [3:0]   mem_wstrb_o,
    input  logic         mem_resp_valid_i,
    input  logic [31:0]  mem_rdata_i
);

    lsu_state_e      state_q, state_d;
    logic            ready_q, ready_d;
    logic            valid_q, valid_d;
    logic            req_valid_q, req_valid_d;
    logic            we_q, we_d;
    logic [3:0]      wstrb_q, wstrb_d;
    logic [31:0]     addr_q, addr_d;
    logic [31:0]     wdata_q, wdata_d;
    logic [2:0]      op_q, op_d;
    logic            is_store_q, is_store_d;
    logic [LSU_WBU_W-1:0] bus_q, bus_d;

    logic [LSU_WBU_W-1:0] in_wbu;
    logic [31:0]     in_addr;
    logic [31:0]     in_wdata;
    logic [2:0]      in_op;
    logic            in_en;
    logic            in_we;
    logic            dev_hit;

    logic [31:0]     al_addr;
    logic [3:0]      al_wstrb;
    logic [31:0]     al_wdata;
    logic            al_misalign;
    logic [31:0]     ld_data;

    assign in_wbu   = exu_lsu_bus_i[LSU_WBU_W-1:0];
    assign in_addr  = exu_lsu_bus_i[WB_FR_HI:WB_FR_LO];
    assign in_wdata = exu_lsu_bus_i[EX_WDATA_HI:EX_WDATA_LO];
    assign in_op    = exu_lsu_bus_i[EX_OP_HI:EX_OP_LO];
    assign in_en    = exu_lsu_bus_i[EX_EN];
    assign in_we    = exu_lsu_bus_i[EX_WE];
    assign dev_hit  = in_window(in_addr, DEV_BASE, DEV_MASK);

    // Request fields come from the incoming bus; load formatting uses the captured instruction
    lsu_align u_align (
        .req_addr_i  (in_addr),
        .req_op_i    (in_op),
        .req_wdata_i (in_wdata),
        .req_addr_o  (al_addr),
        .req_wstrb_o (al_wstrb),
        .req_wdata_o (al_wdata),
        .misalign_o  (al_misalign),
        .ld_addr_i   (bus_q[WB_FR_LO+1:WB_FR_LO]),
        .ld_op_i     (op_q),
        .ld_rdata_i  (mem_rdata_i),
        .ld_data_o   (ld_data)
    );

    // Next-state and next-output logic; every output is registered
    always_comb begin
        state_d     = state_q;
        ready_d     = ready_q;
        valid_d     = valid_q;
        req_valid_d = req_valid_q;
        we_d        = we_q;
        wstrb_d     = wstrb_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        op_d        = op_q;
        is_store_d  = is_store_q;
        bus_d       = bus_q;
        case (state_q)
            ST_IDLE: begin
                if (exu_valid_i) begin
                    ready_d        = 1'b0;
                    op_d           = in_op;
                    is_store_d     = in_we;
                    bus_d          = in_wbu;
                    bus_d[WB_SKIP] = in_wbu[WB_SKIP] | (in_en & dev_hit);
                    if (in_en && al_misalign) begin
                        bus_d[WB_GRWE]  = 1'b0;
                        bus_d[WB_CSRWE] = 1'b0;
                        bus_d[WB_EXCP]  = 1'b1;
                        state_d         = ST_DONE;
                        valid_d         = 1'b1;
                    end else if (in_en) begin
                        state_d     = ST_REQ;
                        req_valid_d = 1'b1;
                        addr_d      = al_addr;
                        we_d        = in_we;
                        wstrb_d     = in_we ? al_wstrb : 4'b0000;
                        wdata_d     = al_wdata;
                    end else begin
                        state_d = ST_DONE;
                        valid_d = 1'b1;
                    end
                end
            end
            ST_REQ: begin
                // A response without the request handshake is not ours yet
                if (mem_req_ready_i) begin
                    req_valid_d = 1'b0;
                    we_d        = 1'b0;
                    wstrb_d     = 4'b0000;
                    if (mem_resp_valid_i) begin
                        if (!is_store_q) begin
                            bus_d[WB_FR_HI:WB_FR_LO] = ld_data;
                        end
                        state_d = ST_DONE;
                        valid_d = 1'b1;
                    end else begin
                        state_d = ST_WAIT;
                    end
                end
            end
            ST_WAIT: begin
                if (mem_resp_valid_i) begin
                    if (!is_store_q) begin
                        bus_d[WB_FR_HI:WB_FR_LO] = ld_data;
                    end
                    state_d = ST_DONE;
                    valid_d = 1'b1;
                end
            end
            ST_DONE: begin
                if (wbu_ready_i) begin
                    state_d = ST_IDLE;
                    valid_d = 1'b0;
                    ready_d = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                ready_d = 1'b1;
                valid_d = 1'b0;
            end
        endcase
    end

    // State and output registers; reset drops any in-flight instruction
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_IDLE;
            ready_q     <= 1'b1;
            valid_q     <= 1'b0;
            req_valid_q <= 1'b0;
            we_q        <= 1'b0;
            wstrb_q     <= 4'b0000;
            addr_q      <= 32'h0;
            wdata_q     <= 32'h0;
            op_q        <= 3'b000;
            is_store_q  <= 1'b0;
            bus_q       <= '0;
        end else begin
            state_q     <= state_d;
            ready_q     <= ready_d;
            valid_q     <= valid_d;
            req_valid_q <= req_valid_d;
            we_q        <= we_d;
            wstrb_q     <= wstrb_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            op_q        <= op_d;
            is_store_q  <= is_store_d;
            bus_q       <= bus_d;
        end
    end

    assign lsu_ready_o     = ready_q;
    assign lsu_valid_o     = valid_q;
    assign lsu_wbu_bus_o   = bus_q;
    assign mem_req_valid_o = req_valid_q;
    assign mem_addr_o      = addr_q;
    assign mem_we_o        = we_q;
    assign mem_wdata_o     = wdata_q;
    assign mem_wstrb_o     = wstrb_q;

endmodule

// File: doc/lsu.md
Name: lsu

Overview:
- Load/store stage between the execute stage and the writeback stage.
- Accepts one instruction at a time from the execute stage over the EXU->LSU bus.
- Performs at most one memory access through a simple request/response port, formats load data and builds store strobes.
- Hands the result to the writeback stage as the 119-bit LSU->WBU bus.

Parameters:
DEV_BASE, 32'ha000_0000, base of the device window; accesses inside it set is_skip_difftest
DEV_MASK, 32'hf000_0000, mask for the device-window compare: (addr & DEV_MASK) == DEV_BASE

Ports:
clock  in  1  clock, rising edge
reset  in  1  asynchronous, active-low reset (asserted when 0)
exu_valid_i  in  1  EXU->LSU bus holds a valid instruction
exu_lsu_bus_i  in  156  {mem_en, mem_we, mem_op[2:0], mem_wdata[31:0], <119-bit LSU->WBU field set>}; address = its final_result field
lsu_ready_o  out  1  LSU can accept an instruction this cycle
lsu_valid_o  out  1  lsu_wbu_bus_o is valid
lsu_wbu_bus_o  out  119  {is_skip_difftest, pc, csr_we, final_result, gr_we, rd, csr_addr, csr_wdata, break, excp_flush, xret_flush}
wbu_ready_i  in  1  writeback stage accepts
mem_req_valid_o  out  1  memory request valid
mem_req_ready_i  in  1  memory accepts the request
mem_addr_o  out  32  access address
mem_we_o  out  1  1 = store
mem_wdata_o  out  32  lane-replicated store data
mem_wstrb_o  out  4  byte strobes (0 for loads)
mem_resp_valid_i  in  1  response (load data or store ack)
mem_rdata_i  in  32  load data word

Behaviour:
- Transfer rules: EXU->LSU transfer on exu_valid_i && lsu_ready_o; the input bus is registered at that edge. LSU->WBU transfer on lsu_valid_o && wbu_ready_i.
- FSM IDLE -> REQ -> WAIT -> DONE.
  - IDLE: lsu_ready_o=1. On transfer, mem_en=1 goes to REQ, mem_en=0 goes to DONE.
  - REQ: mem_req_valid_o=1 with address, data and strobes held stable.
    - mem_req_ready_i=1 and mem_resp_valid_i=1 in the same cycle: capture the response and go to DONE.
    - mem_req_ready_i=1 alone: go to WAIT.
  - WAIT: on mem_resp_valid_i, capture mem_rdata_i and go to DONE.
  - DONE: lsu_valid_o=1. On wbu_ready_i, go to IDLE. No bypass: a new accept happens in the cycle after leaving DONE.
- Latency:
  - Non-memory instruction: lsu_valid_o is high the cycle after accept.
  - Memory access, zero-wait memory: lsu_valid_o is high 2 cycles after accept.
- mem_op uses funct3 coding: 000 b, 001 h, 010 w, 100 bu, 101 hu. Let a = addr[1:0].
  - Loads: lb/lbu select byte rdata[8a+7:8a]; lh/lhu select halfword rdata[16*a[1]+15:16*a[1]]; sign- or zero-extend. Result replaces final_result in the output bus.
  - Stores: sb gives wstrb=4'b0001<<a and wdata={4{b}}; sh gives 4'b0011<<{a[1],1'b0} and {2{h}}; sw gives 4'b1111.
  - Stores pass final_result through unchanged.
- Output is_skip_difftest = input is_skip_difftest OR (mem_en && address in the device window).
- Undefined mem_op values are treated as w.
- Reset values: lsu_valid_o=0, mem_req_valid_o=0, mem_wstrb_o=0, mem_we_o=0, state=IDLE (lsu_ready_o=1).
- Reset mid-operation returns to IDLE and drops the captured instruction. A late mem_resp_valid_i arriving in IDLE or DONE is ignored.
- mem_resp_valid_i arriving while in REQ without mem_req_ready_i is ignored.

Optional Feature:
LSU_MISALIGN_EXCP_EN
- Defined:
  - Misaligned cases are h/hu/sh with a[0]=1, and w/sw with a != 0.
  - A misaligned access issues no memory request; the FSM goes from accept directly to DONE.
  - The output bus carries gr_we=0, csr_we=0 and excp_flush=1.
- Undefined: the address is aligned down (a forced to 0 for w, a[0] forced to 0 for h) and the access proceeds normally.

Decomposition:
- Package lsu_pkg: FSM state enum (IDLE/REQ/WAIT/DONE), mem_op constants, EXU_LSU and LSU_WBU bus widths (156/119), field offsets.
- One sub-module, lsu_align: combinational load extract/extend, store strobe/replication, misalign detect.

Test Plan:
- Non-memory op with final_result=32'h1234 and wbu_ready_i=1 -> lsu_valid_o high 1 cycle after accept; bus final_result=32'h1234; no mem_req_valid_o.
- lb at addr 32'h8000_0003 with rdata=32'h80ff_0000 -> final_result=32'hffff_ff80; lbu gives 32'h0000_0080; mem_wstrb_o=0.
- sh at addr 32'h8000_0002 with wdata=32'h0000_abcd -> mem_wstrb_o=4'b1100, mem_wdata_o=32'habcd_abcd, mem_we_o=1.
- mem_req_ready_i held low 3 cycles, then wbu_ready_i low 2 cycles -> request fields stable throughout; lsu_valid_o held; lsu_ready_o=0 until handoff.
- reset pulled low while in WAIT, then a response arrives after release -> lsu_valid_o=0; response ignored; lsu_ready_o=1.
- lw at addr 32'h8000_0002: macro defined -> no request, excp_flush=1, gr_we=0; macro undefined -> mem_addr_o=32'h8000_0000.
